// File: rtl/ps2_host_tx_pkg.sv
// Shared types and helpers for the PS/2 host-side transmitter.
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        WAIT_CLK,
        SHIFT,
        ACK,
        WAIT_IDLE
    } ps2_tx_state_t;

    // Falls seen before the ACK slot: D0..D7, parity, stop.
    localparam logic [3:0] PS2_LAST_FALL = 4'd9;

    // PS/2 frames carry odd parity over the data byte.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 pin conditioner: 2-FF synchronizer, stability filter, falling-edge strobe.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk28,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic fall
);

    localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Synchronize the pin, then only move the level after FILTER_LEN equal samples.
    always_ff @(posedge clk28) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            fall  <= 1'b0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
            fall  <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
                fall  <= level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, device-clocked frame, ACK.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 28_000_000,
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic       clk28,
    input  logic       rst_n,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       ps2_clk_out,
    output logic       ps2_dat_out,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int unsigned T_INH   = CLK_FREQ / 10000;
    localparam int unsigned T_RTS   = CLK_FREQ / 200000;
    localparam int unsigned T_START = CLK_FREQ * 15 / 1000;
    localparam int unsigned T_FRAME = CLK_FREQ * 2 / 1000;
    localparam int unsigned CNT_W   = $clog2(T_START + 1);

    localparam logic [CNT_W-1:0] LD_INH   = CNT_W'(T_INH - 1);
    localparam logic [CNT_W-1:0] LD_RTS   = CNT_W'(T_RTS - 1);
    localparam logic [CNT_W-1:0] LD_START = CNT_W'(T_START - 1);
    localparam logic [CNT_W-1:0] LD_FRAME = CNT_W'(T_FRAME - 1);

    ps2_tx_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [8:0]       sh_q, sh_d;
    logic             nack_q, nack_d;
    logic             clk_d, dat_d, done_d, err_d;
    logic             tmo, abort;

    logic clk_f, clk_fall;
    logic dat_f;
    // Data-line edges matter only to the receiver sharing this filter.
    logic dat_fall_unused;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk28 (clk28),
        .rst_n (rst_n),
        .pin   (ps2_clk_in),
        .level (clk_f),
        .fall  (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
        .clk28 (clk28),
        .rst_n (rst_n),
        .pin   (ps2_dat_in),
        .level (dat_f),
        .fall  (dat_fall_unused)
    );

    assign tmo = (cnt_q == '0);

    // Next-state and next-output logic; frame bits shift out LSB first with 1s filling behind.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        nack_d  = nack_q;
        clk_d   = ps2_clk_out;
        dat_d   = ps2_dat_out;
        done_d  = 1'b0;
        err_d   = tx_err;
        abort   = 1'b0;

        case (state_q)
            IDLE: begin
                clk_d = 1'b1;
                dat_d = 1'b1;
                if (tx_valid && tx_ready) begin
                    sh_d    = {odd_parity(tx_data), tx_data};
                    err_d   = 1'b0;
                    nack_d  = 1'b0;
                    bit_d   = '0;
                    cnt_d   = LD_INH;
                    clk_d   = 1'b0;
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                if (tmo) begin
                    dat_d   = 1'b0;
                    cnt_d   = LD_RTS;
                    state_d = RTS;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RTS: begin
                if (tmo) begin
                    clk_d   = 1'b1;
                    cnt_d   = LD_START;
                    state_d = WAIT_CLK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WAIT_CLK: begin
                if (clk_fall) begin
                    dat_d   = sh_q[0];
                    sh_d    = {1'b1, sh_q[8:1]};
                    bit_d   = 4'd1;
                    cnt_d   = LD_FRAME;
                    state_d = SHIFT;
                end else if (tmo) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SHIFT: begin
                if (!tmo) cnt_d = cnt_q - 1'b1;
                if (clk_fall) begin
                    dat_d = sh_q[0];
                    sh_d  = {1'b1, sh_q[8:1]};
                    bit_d = bit_q + 4'd1;
                    if (bit_q == PS2_LAST_FALL) state_d = ACK;
                end else if (tmo) begin
                    abort = 1'b1;
                end
            end
            ACK: begin
                if (!tmo) cnt_d = cnt_q - 1'b1;
                if (clk_fall) begin
                    nack_d  = dat_f;
                    state_d = WAIT_IDLE;
                end else if (tmo) begin
                    abort = 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (!tmo) cnt_d = cnt_q - 1'b1;
                if (clk_f && dat_f) begin
                    done_d  = 1'b1;
                    err_d   = nack_q;
                    state_d = IDLE;
                end else if (tmo) begin
                    abort = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            clk_d   = 1'b1;
            dat_d   = 1'b1;
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
        end
    end

    // State, datapath and all outputs registered together.
    always_ff @(posedge clk28) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            sh_q        <= '0;
            nack_q      <= 1'b0;
            ps2_clk_out <= 1'b1;
            ps2_dat_out <= 1'b1;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            sh_q        <= sh_d;
            nack_q      <= nack_d;
            ps2_clk_out <= clk_d;
            ps2_dat_out <= dat_d;
            tx_done     <= done_d;
            tx_err      <= err_d;
            tx_ready    <= (state_d == IDLE);
            busy        <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a behavioural 12 kHz keyboard model.
module tb_ps2_host_tx;

    localparam int unsigned CLK_FREQ   = 1_000_000;
    localparam int unsigned FILTER_LEN = 8;
    localparam int unsigned T_INH      = CLK_FREQ / 10000;
    localparam int unsigned T_RTS      = CLK_FREQ / 200000;
    localparam int unsigned T_START    = CLK_FREQ * 15 / 1000;
    localparam int unsigned T_FRAME    = CLK_FREQ * 2 / 1000;
    localparam int unsigned HALF       = CLK_FREQ / 24000;
    localparam int unsigned QTR        = HALF / 2;
    localparam int unsigned EDGE_LAT   = 2 + FILTER_LEN + 1;
    localparam int unsigned PAUSE      = CLK_FREQ * 25 / 10000;

    logic       clk28 = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       dev_clk, dev_dat;
    logic       ps2_clk_in, ps2_dat_in;
    logic       tx_ready, ps2_clk_out, ps2_dat_out, busy, tx_done, tx_err;

    int unsigned vectors = 0, miscompares = 0;
    int unsigned cyc = 0, acc_count = 0, acc_cyc = 0, acc_seen = 0;
    int unsigned done_count = 0, done_cyc = 0, done_seen = 0;
    logic        done_err = 1'b0, done_clk = 1'b0, done_dat = 1'b0, done_rdy = 1'b0;

    assign ps2_clk_in = ps2_clk_out & dev_clk;
    assign ps2_dat_in = ps2_dat_out & dev_dat;

    ps2_host_tx #(.CLK_FREQ(CLK_FREQ), .FILTER_LEN(FILTER_LEN)) dut (
        .clk28       (clk28),
        .rst_n       (rst_n),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_dat_in  (ps2_dat_in),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ps2_clk_out (ps2_clk_out),
        .ps2_dat_out (ps2_dat_out),
        .busy        (busy),
        .tx_done     (tx_done),
        .tx_err      (tx_err)
    );

    always #5 clk28 = ~clk28;

    // Cycle stamp and accept monitor (pre-edge handshake values).
    always @(posedge clk28) begin
        cyc <= cyc + 1;
        if (rst_n && tx_valid && tx_ready) begin
            acc_count <= acc_count + 1;
            acc_cyc   <= cyc + 1;
        end
    end

    // Completion monitor, sampled mid-cycle.
    always @(negedge clk28) begin
        if (tx_done) begin
            done_count <= done_count + 1;
            done_cyc   <= cyc;
            done_err   <= tx_err;
            done_clk   <= ps2_clk_out;
            done_dat   <= ps2_dat_out;
            done_rdy   <= tx_ready;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Line values a device sees on its 11 rising edges: start, D0..D7, odd parity, stop.
    function automatic logic [10:0] frame_bits(input logic [7:0] d);
        int unsigned ones = 0;
        for (int i = 0; i < 8; i++) ones += d[i];
        return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, d, 1'b0};
    endfunction

    task automatic wait_cycles(input int unsigned n);
        repeat (n) @(negedge clk28);
    endtask

    task automatic start_tx(input logic [7:0] d, input bit keep);
        bit ok = 1'b0;
        if (acc_count == acc_seen) begin
            @(negedge clk28);
            tx_data  = d;
            tx_valid = 1'b1;
            for (int i = 0; i < 4 * T_FRAME; i++) begin
                @(posedge clk28);
                #1;
                if (acc_count != acc_seen) begin
                    ok = 1'b1;
                    break;
                end
            end
        end else begin
            ok = 1'b1;
        end
        chk("accept", ok, 1'b1);
        acc_seen = acc_count;
        if (!keep) tx_valid = 1'b0;
    endtask

    task automatic wait_done(input int unsigned bound);
        bit ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (done_count != done_seen) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk28);
            #1;
        end
        chk("done_seen", ok, 1'b1);
        done_seen = done_count;
    endtask

    // One device clock pulse (entered on a negedge): fall, check host bit timing, rise and sample.
    task automatic dev_bit(input logic exp_bit, output logic smp);
        dev_clk = 1'b0;
        repeat (EDGE_LAT) @(posedge clk28);
        #1 chk("bit_lat", ps2_dat_out, exp_bit);
        @(negedge clk28);
        wait_cycles(HALF - EDGE_LAT - 1);
        dev_clk = 1'b1;
        smp = ps2_dat_out & dev_dat;
        wait_cycles(HALF);
    endtask

    // Keyboard side of one transfer after accept; pause_at>0 stalls the clock before that fall.
    task automatic run_device(input logic [7:0] d, input bit ack_ok, input int unsigned pause_at,
                              input bit exp_err);
        logic [10:0] exp_f = frame_bits(d);
        logic [10:0] got_f = '0;
        logic        s;
        int unsigned ninh = 0, nrts = 0;
        bit          rel = 1'b0, paused = 1'b0;
        @(negedge clk28);
        chk("inh_lat", ps2_clk_out, 1'b0);
        chk("busy", busy, 1'b1);
        chk("not_ready", tx_ready, 1'b0);
        for (int i = 0; i < T_INH + T_RTS + 20; i++) begin
            if (ps2_clk_out) begin
                rel = 1'b1;
                break;
            end
            ninh++;
            if (!ps2_dat_out) nrts++;
            @(negedge clk28);
        end
        chk("clk_release", rel, 1'b1);
        chk("inh_rts_len", ninh, T_INH + T_RTS);
        chk("rts_len", nrts, T_RTS);
        got_f[0] = ps2_dat_out & dev_dat;
        wait_cycles(HALF);
        for (int k = 1; k <= 10; k++) begin
            if (k == pause_at) begin
                wait_cycles(PAUSE);
                paused = 1'b1;
                break;
            end
            dev_bit(exp_f[k], s);
            got_f[k] = s;
        end
        if (!paused) begin
            if (ack_ok) dev_dat = 1'b0;
            wait_cycles(QTR);
            dev_clk = 1'b0;
            wait_cycles(HALF);
            dev_clk = 1'b1;
            wait_cycles(QTR);
            dev_dat = 1'b1;
            chk("frame", got_f, exp_f);
        end
        wait_done(T_FRAME + 100);
        chk("tx_err", done_err, exp_err);
        chk("done_clk_rel", done_clk, 1'b1);
        chk("done_dat_rel", done_dat, 1'b1);
        chk("done_ready", done_rdy, 1'b1);
    endtask

    // Hard stop if something stalls beyond every bounded wait.
    initial begin
        #(2_000_000);
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0]  d;
        logic [10:0] ef;
        logic        s;
        bit          ack_ok, rel;
        int unsigned n;

        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        dev_clk  = 1'b1;
        dev_dat  = 1'b1;
        repeat (3) @(posedge clk28);
        #1;
        chk("rst_clk_out", ps2_clk_out, 1'b1);
        chk("rst_dat_out", ps2_dat_out, 1'b1);
        chk("rst_ready", tx_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", tx_done, 1'b0);
        chk("rst_err", tx_err, 1'b0);
        @(negedge clk28);
        rst_n = 1'b1;
        wait_cycles(20);

        // LED command with ACK.
        start_tx(8'hED, 1'b0);
        run_device(8'hED, 1'b1, 0, 1'b0);

        // Back-to-back with tx_valid held: second byte waits for the first tx_done.
        start_tx(8'hFF, 1'b1);
        tx_data = 8'h00;
        run_device(8'hFF, 1'b1, 0, 1'b0);
        start_tx(8'h00, 1'b0);
        chk("b2b_accept_gap", acc_cyc - done_cyc, 1);
        run_device(8'h00, 1'b1, 0, 1'b0);

        // Device leaves data high in the ACK slot.
        start_tx(8'h3C, 1'b0);
        run_device(8'h3C, 1'b0, 0, 1'b1);

        // Random bytes, mostly acknowledged.
        for (int t = 0; t < 8; t++) begin
            d      = 8'($urandom);
            ack_ok = ($urandom_range(0, 3) != 0);
            start_tx(d, 1'b0);
            run_device(d, ack_ok, 0, !ack_ok);
        end

        // Device stalls its clock for 2.5 ms mid-frame.
        d = 8'($urandom);
        start_tx(d, 1'b0);
        run_device(d, 1'b1, 5, 1'b1);

        // Reset while D4 of 0xA5 is on the line.
        start_tx(8'hA5, 1'b0);
        rel = 1'b0;
        for (int i = 0; i < T_INH + T_RTS + 20; i++) begin
            @(negedge clk28);
            if (ps2_clk_out) begin
                rel = 1'b1;
                break;
            end
        end
        chk("rst_test_release", rel, 1'b1);
        wait_cycles(HALF);
        ef = frame_bits(8'hA5);
        for (int k = 1; k <= 4; k++) dev_bit(ef[k], s);
        dev_clk = 1'b0;
        repeat (EDGE_LAT) @(posedge clk28);
        #1 chk("rst_test_d4", ps2_dat_out, ef[5]);
        n = done_count;
        @(negedge clk28);
        rst_n = 1'b0;
        @(posedge clk28);
        #1;
        chk("midrst_clk_out", ps2_clk_out, 1'b1);
        chk("midrst_dat_out", ps2_dat_out, 1'b1);
        chk("midrst_ready", tx_ready, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", tx_done, 1'b0);
        @(negedge clk28);
        rst_n   = 1'b1;
        dev_clk = 1'b1;
        wait_cycles(3 * HALF);
        chk("midrst_no_done", done_count, n);
        done_seen = done_count;

        // Silent device: start timeout measured from accept.
        start_tx(8'($urandom), 1'b0);
        wait_done(T_INH + T_RTS + T_START + 50);
        chk("start_timeout_len", done_cyc - acc_cyc, T_INH + T_RTS + T_START);
        chk("start_timeout_err", done_err, 1'b1);
        chk("start_timeout_clk", done_clk, 1'b1);
        chk("start_timeout_dat", done_dat, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
